axil_regport_bridge: RTL and testbench
======================================

AXIL_REGPORT_BRIDGE -- requirements
Module: axil_regport_bridge

Interface
REQ-001 Parameter: RD_LAT, default 1, meaning regfile_dout latency in cycles after a regfile_en read cycle; legal range 1..4.
REQ-002 axi_aclk  in  1  single clock for all logic; the regfile port is also timed on this clock.
REQ-003 axi_aresetn  in  1  reset, asynchronous assert, active-low.
REQ-004 s_axi_awaddr  in  12  write address; s_axi_awprot in 3, ignored.
REQ-005 s_axi_awvalid in 1 / s_axi_awready out 1  write-address handshake.
REQ-006 s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1 / s_axi_wready out 1  write-data handshake.
REQ-007 s_axi_bresp out 2, s_axi_bvalid out 1 / s_axi_bready in 1  write response.
REQ-008 s_axi_araddr in 12, s_axi_arprot in 3 (ignored), s_axi_arvalid in 1 / s_axi_arready out 1  read address.
REQ-009 s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1 / s_axi_rready in 1  read data.
REQ-010 regfile_addr out 12, regfile_din out 32, regfile_en out 1, regfile_we out 4  register-port request.
REQ-011 regfile_dout in 32  register-port read data; regfile_rst out 1  equals ~axi_aresetn, combinational.

Function
REQ-012 The FSM SHALL have states IDLE, WR, WRESP, RD, RWAIT, RRESP; one transaction in flight at most.
REQ-013 In IDLE, a write is pending when awvalid and wvalid are both high; a read is pending when arvalid is high.
REQ-014 With only one kind pending, that kind SHALL be granted; with both pending, the kind not granted last SHALL win; after reset, write wins.
REQ-015 A write grant SHALL assert awready and wready together for exactly one cycle (cycle T), latch awaddr, wdata and wstrb, and go to WR.
REQ-016 awready/wready SHALL never be asserted when only one of awvalid/wvalid is high.
REQ-017 WR (cycle T+1): regfile_en=1, regfile_we=latched wstrb, regfile_din=latched wdata, regfile_addr={awaddr[11:2],2'b00}, for exactly one cycle; then WRESP.
REQ-018 wstrb=4'b0000 SHALL still produce the WR cycle, with regfile_we=0 and a normal response.
REQ-019 WRESP: bvalid=1 from T+2, bresp=2'b00, held until bready; on the handshake cycle go to IDLE.
REQ-020 A read grant SHALL assert arready for one cycle (cycle T), latch araddr, and go to RD.
REQ-021 RD (cycle E=T+1): regfile_en=1, regfile_we=0, regfile_addr={araddr[11:2],2'b00}, for one cycle; then RWAIT.
REQ-022 RWAIT SHALL count RD_LAT cycles; regfile_dout SHALL be captured at the end of cycle E+RD_LAT into the rdata register.
REQ-023 RRESP: rvalid=1 from cycle E+RD_LAT+1, rresp=2'b00, rdata stable until rready; on the handshake cycle go to IDLE.
REQ-024 No new grant SHALL occur in the cycle of a B or R handshake; the earliest next grant is the following cycle.
REQ-025 Outside WR/RD: regfile_en=0, regfile_we=0; regfile_addr/din hold their last values.
REQ-026 Address bits [1:0] SHALL be ignored; all 12-bit addresses are accepted with OKAY (no SLVERR/DECERR).
REQ-027 AXI inputs arriving while not in IDLE SHALL be left un-acknowledged and held by the master; none are lost.

Reset
REQ-028 On axi_aresetn low, asynchronously: state=IDLE; awready, wready, arready, bvalid, rvalid, regfile_en=0; regfile_we=0; regfile_addr=0, regfile_din=0, rdata=0, bresp=rresp=0; priority=write.
REQ-029 Reset mid-transaction SHALL abandon it with no response; after release the first grant follows REQ-014.
REQ-030 The first grant SHALL be no earlier than the second rising edge after axi_aresetn deasserts.

Verification
REQ-031 Write 0x00000055 to addr 0x008, wstrb=0xF, bready=1 -> regfile_en=1, we=0xF, addr=0x008, din=0x55 at T+1; bvalid at T+2 with bresp=0.
REQ-032 Read addr 0x004, RD_LAT=1, model returns 0x76543210 -> en at T+1, rvalid at T+3 with rdata=0x76543210; repeat with RD_LAT=3 -> rvalid at T+5.
REQ-033 awvalid high 5 cycles before wvalid -> awready stays 0 until wvalid rises; then awready=wready=1 in the same cycle.
REQ-034 Write and read both pending from reset, continuously -> grants alternate W,R,W,R; bready/rready held low 10 cycles -> valid and data held stable, no new regfile_en.
REQ-035 Unaligned read 0x00B and write with wstrb=0x0 -> regfile_addr=0x008; write gives we=0, bresp=0.
REQ-036 Assert axi_aresetn low during RWAIT -> rvalid and regfile_en immediately 0; after release no stale rvalid; a fresh read completes correctly.

Source files
------------

// File: rtl/axil_regport_bridge.sv
// rtl/axil_regport_bridge.sv - AXI4-Lite slave bridged onto a single-cycle register-file port
// One transaction in flight; write/read alternate when both pending; fixed read latency RD_LAT.
module axil_regport_bridge #(
   parameter int RD_LAT = 1
) (
   input  logic        axi_aclk,
   input  logic        axi_aresetn,
   input  logic [11:0] s_axi_awaddr,
   input  logic [2:0]  s_axi_awprot,
   input  logic        s_axi_awvalid,
   output logic        s_axi_awready,
   input  logic [31:0] s_axi_wdata,
   input  logic [3:0]  s_axi_wstrb,
   input  logic        s_axi_wvalid,
   output logic        s_axi_wready,
   output logic [1:0]  s_axi_bresp,
   output logic        s_axi_bvalid,
   input  logic        s_axi_bready,
   input  logic [11:0] s_axi_araddr,
   input  logic [2:0]  s_axi_arprot,
   input  logic        s_axi_arvalid,
   output logic        s_axi_arready,
   output logic [31:0] s_axi_rdata,
   output logic [1:0]  s_axi_rresp,
   output logic        s_axi_rvalid,
   input  logic        s_axi_rready,
   output logic [11:0] regfile_addr,
   output logic [31:0] regfile_din,
   output logic        regfile_en,
   output logic [3:0]  regfile_we,
   input  logic [31:0] regfile_dout,
   output logic        regfile_rst
);

   typedef enum logic [2:0] {IDLE, WR, WRESP, RD, RWAIT, RRESP} state_t;

   localparam logic [2:0] LAT = 3'(RD_LAT);

   state_t     state;
   logic       armed;
   logic       last_wr;
   logic [2:0] lat_cnt;
   logic       wr_pend;
   logic       rd_pend;
   logic       unused_inputs;

   assign wr_pend = s_axi_awvalid & s_axi_wvalid;
   assign rd_pend = s_axi_arvalid;

   assign s_axi_bresp   = 2'b00;
   assign s_axi_rresp   = 2'b00;
   assign regfile_rst   = ~axi_aresetn;
   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

   always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
      if (!axi_aresetn) begin
         state         <= IDLE;
         armed         <= 1'b0;
         last_wr       <= 1'b0;
         lat_cnt       <= 3'd0;
         s_axi_awready <= 1'b0;
         s_axi_wready  <= 1'b0;
         s_axi_arready <= 1'b0;
         s_axi_bvalid  <= 1'b0;
         s_axi_rvalid  <= 1'b0;
         s_axi_rdata   <= 32'd0;
         regfile_en    <= 1'b0;
         regfile_we    <= 4'd0;
         regfile_addr  <= 12'd0;
         regfile_din   <= 32'd0;
      end else begin
         // armed stays low for the first edge after reset so no grant precedes the second edge
         armed <= 1'b1;
         case (state)
            IDLE: begin
               if (s_axi_awready) begin
                  s_axi_awready <= 1'b0;
                  s_axi_wready  <= 1'b0;
                  if (wr_pend) begin
                     regfile_en   <= 1'b1;
                     regfile_we   <= s_axi_wstrb;
                     regfile_addr <= {s_axi_awaddr[11:2], 2'b00};
                     regfile_din  <= s_axi_wdata;
                     last_wr      <= 1'b1;
                     state        <= WR;
                  end
               end else if (s_axi_arready) begin
                  s_axi_arready <= 1'b0;
                  if (rd_pend) begin
                     regfile_en   <= 1'b1;
                     regfile_we   <= 4'd0;
                     regfile_addr <= {s_axi_araddr[11:2], 2'b00};
                     last_wr      <= 1'b0;
                     state        <= RD;
                  end
               end else if (armed) begin
                  if (wr_pend && (!rd_pend || !last_wr)) begin
                     s_axi_awready <= 1'b1;
                     s_axi_wready  <= 1'b1;
                  end else if (rd_pend) begin
                     s_axi_arready <= 1'b1;
                  end
               end
            end
            WR: begin
               regfile_en   <= 1'b0;
               regfile_we   <= 4'd0;
               s_axi_bvalid <= 1'b1;
               state        <= WRESP;
            end
            WRESP: begin
               if (s_axi_bready) begin
                  s_axi_bvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            RD: begin
               regfile_en <= 1'b0;
               lat_cnt    <= 3'd1;
               state      <= RWAIT;
            end
            RWAIT: begin
               if (lat_cnt == LAT) begin
                  s_axi_rdata  <= regfile_dout;
                  s_axi_rvalid <= 1'b1;
                  state        <= RRESP;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            RRESP: begin
               if (s_axi_rready) begin
                  s_axi_rvalid <= 1'b0;
                  state        <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_axil_regport_bridge.sv
// tb/tb_axil_regport_bridge.sv - directed and randomized checks of axil_regport_bridge
// Two instances (read latency 1 and 3) against a word-array reference of register contents.
module tb_axil_regport_bridge;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic [11:0] awaddr [2];
   logic        awvalid[2];
   logic [31:0] wdata  [2];
   logic [3:0]  wstrb  [2];
   logic        wvalid [2];
   logic        bready [2];
   logic [11:0] araddr [2];
   logic        arvalid[2];
   logic        rready [2];
   logic        awready[2];
   logic        wready [2];
   logic [1:0]  bresp  [2];
   logic        bvalid [2];
   logic        arready[2];
   logic [31:0] rdata  [2];
   logic [1:0]  rresp  [2];
   logic        rvalid [2];
   logic [11:0] reg_addr[2];
   logic [31:0] reg_din [2];
   logic        reg_en  [2];
   logic [3:0]  reg_we  [2];
   logic [31:0] reg_dout[2];
   logic        reg_rst [2];

   logic [31:0] ref_mem[2][1024];
   int vec;
   int errs;

   function automatic logic [31:0] init_word(input int i);
      if (i == 1) return 32'h7654_3210;
      return 32'h3C00_0000 ^ (32'(i) * 32'h0001_0F01);
   endfunction

   axil_regport_bridge #(.RD_LAT(1)) u_dut0 (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr[0]), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid[0]), .s_axi_awready(awready[0]),
      .s_axi_wdata(wdata[0]), .s_axi_wstrb(wstrb[0]), .s_axi_wvalid(wvalid[0]), .s_axi_wready(wready[0]),
      .s_axi_bresp(bresp[0]), .s_axi_bvalid(bvalid[0]), .s_axi_bready(bready[0]),
      .s_axi_araddr(araddr[0]), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid[0]), .s_axi_arready(arready[0]),
      .s_axi_rdata(rdata[0]), .s_axi_rresp(rresp[0]), .s_axi_rvalid(rvalid[0]), .s_axi_rready(rready[0]),
      .regfile_addr(reg_addr[0]), .regfile_din(reg_din[0]), .regfile_en(reg_en[0]), .regfile_we(reg_we[0]),
      .regfile_dout(reg_dout[0]), .regfile_rst(reg_rst[0])
   );

   axil_regport_bridge #(.RD_LAT(3)) u_dut1 (
      .axi_aclk(clk), .axi_aresetn(rst_n),
      .s_axi_awaddr(awaddr[1]), .s_axi_awprot(3'b000), .s_axi_awvalid(awvalid[1]), .s_axi_awready(awready[1]),
      .s_axi_wdata(wdata[1]), .s_axi_wstrb(wstrb[1]), .s_axi_wvalid(wvalid[1]), .s_axi_wready(wready[1]),
      .s_axi_bresp(bresp[1]), .s_axi_bvalid(bvalid[1]), .s_axi_bready(bready[1]),
      .s_axi_araddr(araddr[1]), .s_axi_arprot(3'b000), .s_axi_arvalid(arvalid[1]), .s_axi_arready(arready[1]),
      .s_axi_rdata(rdata[1]), .s_axi_rresp(rresp[1]), .s_axi_rvalid(rvalid[1]), .s_axi_rready(rready[1]),
      .regfile_addr(reg_addr[1]), .regfile_din(reg_din[1]), .regfile_en(reg_en[1]), .regfile_we(reg_we[1]),
      .regfile_dout(reg_dout[1]), .regfile_rst(reg_rst[1])
   );

   // Register-file slave: data appears exactly L cycles after a read-enable cycle, garbage otherwise
   for (genvar g = 0; g < 2; g++) begin : g_rf
      localparam int L = (g == 0) ? 1 : 3;
      logic [31:0] mem [1024];
      bit          written [1024];
      logic [31:0] pipe [4];
      always @(posedge clk) begin : rf_seq
         logic [31:0] w;
         int idx;
         idx = int'(reg_addr[g][11:2]);
         pipe[0] <= (reg_en[g] && reg_we[g] == 4'd0) ? (written[idx] ? mem[idx] : init_word(idx)) : 32'hDEAD_BEEF;
         for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
         if (reg_en[g] && reg_we[g] != 4'd0) begin
            w = written[idx] ? mem[idx] : init_word(idx);
            for (int b = 0; b < 4; b++)
               if (reg_we[g][b]) w[8*b +: 8] = reg_din[g][8*b +: 8];
            mem[idx]     <= w;
            written[idx] <= 1'b1;
         end
      end
      assign reg_dout[g] = pipe[L-1];
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_grant(input int d, output int kind);
      kind = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (awready[d] || arready[d]) begin
            kind = awready[d] ? 1 : 2;
            break;
         end
      end
      check("grant_seen", 32'(kind != 0), 1);
      check("aw_w_ready_together", 32'(wready[d]), 32'(awready[d]));
      check("single_grant", 32'(awready[d] & arready[d]), 0);
   endtask

   task automatic finish_write(input int d, input int hold, input bit again);
      logic [11:0] a;
      logic [31:0] dat;
      logic [3:0]  s;
      a = awaddr[d]; dat = wdata[d]; s = wstrb[d];
      @(posedge clk); #1;
      if (again) begin
         awaddr[d] = 12'($urandom_range(255, 0));
         wdata[d]  = $urandom;
         wstrb[d]  = 4'($urandom);
      end else begin
         awvalid[d] = 1'b0;
         wvalid[d]  = 1'b0;
      end
      check("wr_en", 32'(reg_en[d]), 1);
      check("wr_we", 32'(reg_we[d]), 32'(s));
      check("wr_addr", 32'(reg_addr[d]), 32'({a[11:2], 2'b00}));
      check("wr_din", reg_din[d], dat);
      for (int b = 0; b < 4; b++)
         if (s[b]) ref_mem[d][a[11:2]][8*b +: 8] = dat[8*b +: 8];
      @(posedge clk); #1;
      check("bvalid", 32'(bvalid[d]), 1);
      check("bresp", 32'(bresp[d]), 0);
      check("wresp_en_low", 32'(reg_en[d]), 0);
      check("b_no_grant", 32'(awready[d] | arready[d]), 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("bvalid_hold", 32'(bvalid[d]), 1);
         check("b_hold_no_en", 32'(reg_en[d]), 0);
         check("b_hold_no_grant", 32'(awready[d] | arready[d]), 0);
      end
      bready[d] = 1'b1;
      @(posedge clk); #1;
      bready[d] = 1'b0;
      check("bvalid_drop", 32'(bvalid[d]), 0);
   endtask

   task automatic finish_read(input int d, input int hold, input int lat, input bit again);
      logic [11:0] a;
      logic [31:0] exp_d;
      int cyc;
      a = araddr[d];
      @(posedge clk); #1;
      if (again) araddr[d] = 12'($urandom_range(255, 0));
      else arvalid[d] = 1'b0;
      check("rd_en", 32'(reg_en[d]), 1);
      check("rd_we", 32'(reg_we[d]), 0);
      check("rd_addr", 32'(reg_addr[d]), 32'({a[11:2], 2'b00}));
      exp_d = ref_mem[d][a[11:2]];
      cyc = 0;
      do begin
         @(posedge clk); #1;
         cyc++;
         if (!rvalid[d]) check("rwait_en_low", 32'(reg_en[d]), 0);
      end while (!rvalid[d] && cyc < 12);
      check("r_latency", 32'(cyc), 32'(lat + 1));
      check("rdata", rdata[d], exp_d);
      check("rresp", 32'(rresp[d]), 0);
      check("r_no_grant", 32'(awready[d] | arready[d]), 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         check("rvalid_hold", 32'(rvalid[d]), 1);
         check("rdata_hold", rdata[d], exp_d);
         check("r_hold_no_en", 32'(reg_en[d]), 0);
      end
      rready[d] = 1'b1;
      @(posedge clk); #1;
      rready[d] = 1'b0;
      check("rvalid_drop", 32'(rvalid[d]), 0);
   endtask

   initial begin
      int kind;
      vec = 0;
      errs = 0;
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < 1024; i++) ref_mem[d][i] = init_word(i);
         awaddr[d] = '0; awvalid[d] = 0; wdata[d] = '0; wstrb[d] = '0; wvalid[d] = 0; bready[d] = 0;
         araddr[d] = '0; arvalid[d] = 0; rready[d] = 0;
      end
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         check("rst_awready", 32'(awready[d]), 0);
         check("rst_wready", 32'(wready[d]), 0);
         check("rst_arready", 32'(arready[d]), 0);
         check("rst_bvalid", 32'(bvalid[d]), 0);
         check("rst_rvalid", 32'(rvalid[d]), 0);
         check("rst_en", 32'(reg_en[d]), 0);
         check("rst_we", 32'(reg_we[d]), 0);
         check("rst_addr", 32'(reg_addr[d]), 0);
         check("rst_din", reg_din[d], 0);
         check("rst_rdata", rdata[d], 0);
         check("rst_regfile_rst", 32'(reg_rst[d]), 1);
      end

      // Write and read both pending across reset release: W,R,W,R with long response stalls
      awaddr[0] = 12'h008; wdata[0] = 32'h0000_0055; wstrb[0] = 4'hF; awvalid[0] = 1; wvalid[0] = 1;
      araddr[0] = 12'h004; arvalid[0] = 1;
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      check("first_edge_no_grant", 32'(awready[0] | arready[0]), 0);
      check("regfile_rst_released", 32'(reg_rst[0]), 0);
      wait_grant(0, kind); check("grant1_write", 32'(kind), 1);
      finish_write(0, 10, 1);
      wait_grant(0, kind); check("grant2_read", 32'(kind), 2);
      finish_read(0, 10, 1, 1);
      wait_grant(0, kind); check("grant3_write", 32'(kind), 1);
      finish_write(0, 0, 0);
      wait_grant(0, kind); check("grant4_read", 32'(kind), 2);
      finish_read(0, 0, 1, 0);

      // awvalid alone must not be acknowledged
      awaddr[0] = 12'h100; wdata[0] = 32'hCAFE_0001; wstrb[0] = 4'hF; awvalid[0] = 1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         check("aw_only_no_awready", 32'(awready[0]), 0);
         check("aw_only_no_wready", 32'(wready[0]), 0);
      end
      wvalid[0] = 1;
      wait_grant(0, kind); check("grant_after_wvalid", 32'(kind), 1);
      finish_write(0, 0, 0);

      // Unaligned accesses and an all-zero strobe
      araddr[0] = 12'h00B; arvalid[0] = 1;
      wait_grant(0, kind); check("unaligned_read_grant", 32'(kind), 2);
      finish_read(0, 0, 1, 0);
      awaddr[0] = 12'h00B; wdata[0] = 32'hFFFF_FFFF; wstrb[0] = 4'h0; awvalid[0] = 1; wvalid[0] = 1;
      wait_grant(0, kind); check("zero_strb_grant", 32'(kind), 1);
      finish_write(0, 1, 0);
      araddr[0] = 12'h008; arvalid[0] = 1;
      wait_grant(0, kind); check("readback_grant", 32'(kind), 2);
      finish_read(0, 0, 1, 0);

      // Three-cycle read latency instance
      araddr[1] = 12'h004; arvalid[1] = 1;
      wait_grant(1, kind); check("lat3_grant", 32'(kind), 2);
      finish_read(1, 2, 3, 0);

      // Randomized traffic on both instances
      for (int n = 0; n < 32; n++) begin
         int d;
         d = n % 2;
         if ($urandom_range(1, 0) == 1) begin
            awaddr[d] = 12'($urandom_range(63, 0)); wdata[d] = $urandom; wstrb[d] = 4'($urandom);
            awvalid[d] = 1; wvalid[d] = 1;
            wait_grant(d, kind); check("rand_write_grant", 32'(kind), 1);
            finish_write(d, $urandom_range(2, 0), 0);
         end else begin
            araddr[d] = 12'($urandom_range(63, 0)); arvalid[d] = 1;
            wait_grant(d, kind); check("rand_read_grant", 32'(kind), 2);
            finish_read(d, $urandom_range(2, 0), (d == 0) ? 1 : 3, 0);
         end
      end

      // Reset during the read-latency wait abandons the read
      araddr[1] = 12'h010; arvalid[1] = 1;
      wait_grant(1, kind); check("abort_read_grant", 32'(kind), 2);
      @(posedge clk); #1;
      arvalid[1] = 0;
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("abort_rvalid", 32'(rvalid[1]), 0);
      check("abort_en", 32'(reg_en[1]), 0);
      check("abort_arready", 32'(arready[1]), 0);
      check("abort_rdata", rdata[1], 0);
      check("abort_regfile_rst", 32'(reg_rst[1]), 1);
      @(posedge clk); #4;
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         check("no_stale_rvalid", 32'(rvalid[1]), 0);
         check("no_stale_en", 32'(reg_en[1]), 0);
      end
      araddr[1] = 12'h010; arvalid[1] = 1;
      wait_grant(1, kind); check("fresh_read_grant", 32'(kind), 2);
      finish_read(1, 0, 3, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end

endmodule
